serial_tx: RTL and testbench

Parameterised serial frame transmitter: accepts a parallel word over a valid/ready handshake and shifts it out on a single line as start bit, DATA_W data bits LSB-first, then stop bit. Each bit is held for CLKS_PER_BIT clocks. It is the transmitting end of the lab's serial link, built from clocked storage and shift-register practice. It drives the receive-side capture chain and board-level loopback exercises.

---
 rtl/serial_tx_if.sv | 20 ++
 rtl/serial_tx.sv | 90 +++++++++
 tb/tb_serial_tx.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_tx_if.sv
// Valid/ready word handshake between a word source (master) and the serial transmitter (slave).
interface serial_tx_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/serial_tx.sv
// Serial frame transmitter: start bit, DATA_W data bits LSB-first, then stop bit,
// each bit held on the line for CLKS_PER_BIT clocks.
module serial_tx #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    serial_tx_if.slave tx_if,
    output logic       tx_out,
    output logic       busy
);
    localparam int unsigned CycW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BitW = $clog2(DATA_W + 1);
    localparam logic [CycW-1:0] CycLast = CycW'(CLKS_PER_BIT - 1);
    localparam logic [BitW-1:0] BitLast = BitW'(DATA_W - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BitW-1:0]   bit_q, bit_d;
    logic [CycW-1:0]   cyc_q, cyc_d;
    logic              bit_done;

    assign bit_done = (cyc_q == CycLast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            shift_q <= '0;
            bit_q   <= '0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            cyc_q   <= cyc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        cyc_d   = cyc_q;
        // The cycle counter only runs inside a frame and wraps at every bit boundary.
        if (state_q != StIdle) begin
            cyc_d = bit_done ? '0 : cyc_q + CycW'(1);
        end
        unique case (state_q)
            StIdle: begin
                if (tx_if.tx_valid) begin
                    shift_d = tx_if.tx_data;
                    bit_d   = '0;
                    cyc_d   = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_done) state_d = StData;
            end
            StData: begin
                if (bit_done) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + BitW'(1);
                    if (bit_q == BitLast) state_d = StStop;
                end
            end
            StStop: begin
                if (bit_done) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decode registered state only, so reset forces the idle line at once.
    always_comb begin
        tx_out         = 1'b1;
        busy           = (state_q != StIdle);
        tx_if.tx_ready = (state_q == StIdle);
        unique case (state_q)
            StIdle:  tx_out = 1'b1;
            StStart: tx_out = 1'b0;
            StData:  tx_out = shift_q[0];
            StStop:  tx_out = 1'b1;
            default: tx_out = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx: directed frame table, multi-cycle corner cases,
// then randomized traffic against a frame-level reference model.
module tb_serial_tx;
    localparam int DATA_W    = 8;
    localparam int CPB       = 4;
    localparam int FRAME_CYC = (DATA_W + 2) * CPB;

    logic clk;
    logic rst_n;
    logic tx_out;
    logic busy;

    serial_tx_if #(.DATA_W(DATA_W)) tx_if ();

    serial_tx #(
        .DATA_W      (DATA_W),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tx_if (tx_if),
        .tx_out(tx_out),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is the word wrapped in start/stop bits; the line shows
    // frame bit (cycles since handshake / CPB) until the whole frame has elapsed.
    logic              m_busy;
    int                m_pos;
    logic [DATA_W+1:0] m_frame;
    logic              exp_out;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_pos   <= 0;
            m_frame <= '1;
        end else if (!m_busy) begin
            if (tx_if.tx_valid) begin
                m_busy  <= 1'b1;
                m_pos   <= 0;
                m_frame <= {1'b1, tx_if.tx_data, 1'b0};
            end
        end else if (m_pos == FRAME_CYC - 1) begin
            m_busy <= 1'b0;
        end else begin
            m_pos <= m_pos + 1;
        end
    end

    always_comb exp_out = m_busy ? m_frame[m_pos / CPB] : 1'b1;

    typedef struct {
        logic [7:0] word;
        logic [0:9] seq;     // line level per bit slot, start bit first
        bit         mangle;  // overwrite tx_data right after the handshake
        bit         pulse;   // pulse tx_valid with 8'hFF mid-frame
    } frame_vec_t;

    frame_vec_t vecs[4];
    frame_vec_t v0f;

    // Handshake v.word from idle and follow the whole frame cycle by cycle.
    task automatic run_frame(input frame_vec_t v, input string tag);
        @(negedge clk);
        tx_if.tx_data  = v.word;
        tx_if.tx_valid = 1'b1;
        @(negedge clk);
        tx_if.tx_valid = 1'b0;
        for (int c = 0; c < FRAME_CYC; c++) begin
            check({tag, "_line"}, 32'(tx_out), 32'(v.seq[c / CPB]));
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_ready"}, 32'(tx_if.tx_ready), 32'd0);
            if (c == 0 && v.mangle) tx_if.tx_data = 8'h00;
            if (c == 20 && v.pulse) begin
                tx_if.tx_data  = 8'hFF;
                tx_if.tx_valid = 1'b1;
            end
            if (c == 21) tx_if.tx_valid = 1'b0;
            @(negedge clk);
        end
        check({tag, "_end_busy"}, 32'(busy), 32'd0);
        check({tag, "_end_ready"}, 32'(tx_if.tx_ready), 32'd1);
        check({tag, "_end_line"}, 32'(tx_out), 32'd1);
        if (v.pulse) begin
            for (int c = 0; c < CPB + 2; c++) begin
                @(negedge clk);
                check({tag, "_stay_idle"}, 32'(tx_out), 32'd1);
                check({tag, "_stay_notbusy"}, 32'(busy), 32'd0);
            end
        end
    endtask

    initial begin
        logic [0:9] s01;
        logic [0:9] s80;
        logic [0:9] s55;
        logic       expv;
        int         high_run;

        vecs[0] = '{word: 8'hA5, seq: 10'b0101001011, mangle: 1'b0, pulse: 1'b0};
        vecs[1] = '{word: 8'h3C, seq: 10'b0001111001, mangle: 1'b1, pulse: 1'b0};
        vecs[2] = '{word: 8'h5A, seq: 10'b0010110101, mangle: 1'b0, pulse: 1'b1};
        vecs[3] = '{word: 8'hFF, seq: 10'b0111111111, mangle: 1'b0, pulse: 1'b0};
        v0f     = '{word: 8'h0F, seq: 10'b0111100001, mangle: 1'b0, pulse: 1'b0};
        s01 = 10'b0100000001;
        s80 = 10'b0000000011;
        s55 = 10'b0101010101;

        // Reset held with tx_valid asserted: nothing may be accepted.
        rst_n          = 1'b0;
        tx_if.tx_valid = 1'b1;
        tx_if.tx_data  = 8'hAA;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("rst_line", 32'(tx_out), 32'd1);
            check("rst_ready", 32'(tx_if.tx_ready), 32'd1);
            check("rst_busy", 32'(busy), 32'd0);
        end
        tx_if.tx_valid = 1'b0;
        rst_n          = 1'b1;
        @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_line", 32'(tx_out), 32'd1);

        foreach (vecs[i]) run_frame(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back: tx_valid held high across two frames.
        @(negedge clk);
        tx_if.tx_data  = 8'h01;
        tx_if.tx_valid = 1'b1;
        @(negedge clk);
        tx_if.tx_data = 8'h80;
        high_run      = 0;
        for (int c = 0; c <= 2 * FRAME_CYC; c++) begin
            if (c < FRAME_CYC) expv = s01[c / CPB];
            else if (c == FRAME_CYC) expv = 1'b1;
            else expv = s80[(c - FRAME_CYC - 1) / CPB];
            check("b2b_line", 32'(tx_out), 32'(expv));
            if (c == FRAME_CYC) check("b2b_gap_ready", 32'(tx_if.tx_ready), 32'd1);
            if (c <= FRAME_CYC) high_run = tx_out ? high_run + 1 : 0;
            if (c == FRAME_CYC + 1) tx_if.tx_valid = 1'b0;
            @(negedge clk);
        end
        check("b2b_gap_len", 32'(high_run), 32'(CPB + 1));
        check("b2b_end_busy", 32'(busy), 32'd0);

        // Abort mid-frame with an asynchronous reset.
        tx_if.tx_data  = 8'h55;
        tx_if.tx_valid = 1'b1;
        @(negedge clk);
        tx_if.tx_valid = 1'b0;
        for (int c = 0; c <= 13; c++) begin
            check("abort_line", 32'(tx_out), 32'(s55[c / CPB]));
            if (c < 13) @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check("abort_line_now", 32'(tx_out), 32'd1);
        check("abort_busy_now", 32'(busy), 32'd0);
        check("abort_ready_now", 32'(tx_if.tx_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(v0f, "after_abort");

        // Randomized traffic against the reference model, with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            check("rnd_line", 32'(tx_out), 32'(exp_out));
            check("rnd_busy", 32'(busy), 32'(m_busy));
            check("rnd_ready", 32'(tx_if.tx_ready), 32'(!m_busy));
            tx_if.tx_valid = ($urandom_range(0, 3) == 0);
            tx_if.tx_data  = 8'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                #1;
                check("rnd_rst_line", 32'(tx_out), 32'(exp_out));
                check("rnd_rst_busy", 32'(busy), 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
